// File: rtl/multicycle_control_pkg.sv
// Shared codes for the multicycle controller: ALU ops, branch selects, opcodes, FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package multicycle_control_pkg;

   // ALU operation codes, shared with the ALU datapath
   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_SLL  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLLI = 4'b1100;
   localparam logic [3:0] ALU_SRLI = 4'b1101;

   // ALU condition selects; branch funct3 maps onto these directly
   localparam logic [2:0] BR_BEQ  = 3'b000;
   localparam logic [2:0] BR_BNE  = 3'b001;
   localparam logic [2:0] BR_JAL  = 3'b010;
   localparam logic [2:0] BR_BLT  = 3'b100;
   localparam logic [2:0] BR_BGE  = 3'b101;
   localparam logic [2:0] BR_BLTU = 3'b110;
   localparam logic [2:0] BR_BGEU = 3'b111;
   localparam logic [2:0] BR_NONE = 3'b000;

   // Major opcodes
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [2:0] F3_WORD = 3'b010;

   // Write-back source select
   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   // FSM states
   localparam logic [2:0] ST_FETCH   = 3'd0;
   localparam logic [2:0] ST_DECODE  = 3'd1;
   localparam logic [2:0] ST_EXECUTE = 3'd2;
   localparam logic [2:0] ST_MEM     = 3'd3;
   localparam logic [2:0] ST_WB      = 3'd4;
   localparam logic [2:0] ST_TRAP    = 3'd5;

   typedef enum logic [2:0] {
      CLS_ALU,
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH,
      CLS_JAL
   } instr_class_t;

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational instruction decoder: instruction word -> alu_op, branch, operand select, class, legal.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows the input word.
module instr_decode
   import multicycle_control_pkg::*;
(
   input  logic [31:0]  instr,
   output logic [3:0]   alu_op,
   output logic [2:0]   branch,
   output logic         alu_src_b,
   output instr_class_t cls,
   output logic         legal
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       unused_fields;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   // register and immediate fields do not influence control
   assign unused_fields = ^{instr[24:15], instr[11:7]};

   // Illegal words fall through with ADD / no branch / rs2 so the outputs stay benign
   always_comb begin
      alu_op    = ALU_ADD;
      branch    = BR_NONE;
      alu_src_b = 1'b0;
      cls       = CLS_ALU;
      legal     = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            if (funct7 == F7_BASE) begin
               legal = 1'b1;
               case (funct3)
                  3'b000:  alu_op = ALU_ADD;
                  3'b001:  alu_op = ALU_SLL;
                  3'b100:  alu_op = ALU_XOR;
                  3'b101:  alu_op = ALU_SRL;
                  3'b110:  alu_op = ALU_OR;
                  3'b111:  alu_op = ALU_AND;
                  default: legal  = 1'b0;
               endcase
            end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
               legal  = 1'b1;
               alu_op = ALU_SUB;
            end
            if (!legal) alu_op = ALU_ADD;
         end
         OP_ITYPE: begin
            legal = 1'b1;
            case (funct3)
               3'b000:  alu_op = ALU_ADD;
               3'b100:  alu_op = ALU_XOR;
               3'b110:  alu_op = ALU_OR;
               3'b111:  alu_op = ALU_AND;
               3'b001:  if (funct7 == F7_BASE) alu_op = ALU_SLLI; else legal = 1'b0;
               3'b101:  if (funct7 == F7_BASE) alu_op = ALU_SRLI; else legal = 1'b0;
               default: legal = 1'b0;
            endcase
            if (legal) alu_src_b = 1'b1;
            else       alu_op    = ALU_ADD;
         end
         OP_LOAD: begin
            if (funct3 == F3_WORD) begin
               legal     = 1'b1;
               cls       = CLS_LOAD;
               alu_src_b = 1'b1;
            end
         end
         OP_STORE: begin
            if (funct3 == F3_WORD) begin
               legal     = 1'b1;
               cls       = CLS_STORE;
               alu_src_b = 1'b1;
            end
         end
         OP_BRANCH: begin
            // funct3 010/011 are the only unassigned branch codes
            if (funct3[2:1] != 2'b01) begin
               legal  = 1'b1;
               cls    = CLS_BRANCH;
               alu_op = ALU_SUB;
               branch = funct3;
            end
         end
         OP_JAL: begin
            legal  = 1'b1;
            cls    = CLS_JAL;
            branch = BR_JAL;
         end
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32 subset control FSM: FETCH/DECODE/EXECUTE/MEM/WB/TRAP with Moore strobes.
// Latency: 3 cycles (branch), 4 (ALU/JAL/SW), 5 (LW) plus memory wait cycles.
// Backpressure: FETCH and MEM hold with mem_req high until mem_ready; reset abandons the request.
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int alu_op_size = 4,
   parameter int instr_size  = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [instr_size-1:0]  instr_rdata,
   input  logic                   mem_ready,
   input  logic                   zero,
   output logic [alu_op_size-1:0] alu_op,
   output logic [2:0]             branch,
   output logic                   alu_src_b,
   output logic                   mem_req,
   output logic                   mem_we,
   output logic                   ir_we,
   output logic                   reg_we,
   output logic                   pc_we,
   output logic                   pc_sel,
   output logic [1:0]             wb_sel,
   output logic                   illegal
);

   logic [2:0]            state;
   logic [instr_size-1:0] ir;
   // Low for the first cycle out of reset so mem_req drops while the abandoned
   // memory transaction drains; FETCH only issues requests once this is set.
   logic                  fetch_arm;

   logic [3:0]   dec_alu_op;
   logic [2:0]   dec_branch;
   logic         dec_alu_src_b;
   instr_class_t dec_cls;
   logic         dec_legal;

   instr_decode u_decode (
      .instr     (ir[31:0]),
      .alu_op    (dec_alu_op),
      .branch    (dec_branch),
      .alu_src_b (dec_alu_src_b),
      .cls       (dec_cls),
      .legal     (dec_legal)
   );

   // ALU controls come straight from the latched instruction, so they stay stable through EXECUTE and MEM
   assign alu_op    = alu_op_size'(dec_alu_op);
   assign branch    = dec_branch;
   assign alu_src_b = dec_alu_src_b;
   assign illegal   = (state == ST_TRAP);

   // State register and instruction latch
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_FETCH;
         ir        <= '0;
         fetch_arm <= 1'b0;
      end else begin
         fetch_arm <= 1'b1;
         case (state)
            ST_FETCH: begin
               if (fetch_arm && mem_ready) begin
                  ir    <= instr_rdata;
                  state <= ST_DECODE;
               end
            end
            ST_DECODE:  state <= dec_legal ? ST_EXECUTE : ST_TRAP;
            ST_EXECUTE: begin
               case (dec_cls)
                  CLS_BRANCH:          state <= ST_FETCH;
                  CLS_LOAD, CLS_STORE: state <= ST_MEM;
                  default:             state <= ST_WB;
               endcase
            end
            ST_MEM: begin
               if (mem_ready) state <= (dec_cls == CLS_LOAD) ? ST_WB : ST_FETCH;
            end
            ST_WB:   state <= ST_FETCH;
            ST_TRAP: state <= ST_TRAP;
            default: state <= ST_FETCH;
         endcase
      end
   end

   // Strobes: Moore on state and latched instruction; mem_ready gates the single-cycle
   // completion strobes and zero reaches only pc_sel
   always_comb begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      ir_we   = 1'b0;
      reg_we  = 1'b0;
      pc_we   = 1'b0;
      pc_sel  = 1'b0;
      wb_sel  = WB_ALU;
      case (state)
         ST_FETCH: begin
            mem_req = fetch_arm;
            ir_we   = fetch_arm & mem_ready;
         end
         ST_EXECUTE: begin
            case (dec_cls)
               CLS_BRANCH: begin
                  pc_we  = 1'b1;
                  pc_sel = zero;
               end
               CLS_JAL: begin
                  pc_we  = 1'b1;
                  pc_sel = 1'b1;
               end
               default: pc_we = 1'b0;
            endcase
         end
         ST_MEM: begin
            mem_req = 1'b1;
            mem_we  = (dec_cls == CLS_STORE);
            pc_we   = (dec_cls == CLS_STORE) & mem_ready;
         end
         ST_WB: begin
            reg_we = 1'b1;
            pc_we  = (dec_cls != CLS_JAL);
            if (dec_cls == CLS_LOAD)     wb_sel = WB_MEM;
            else if (dec_cls == CLS_JAL) wb_sel = WB_PC4;
            else                         wb_sel = WB_ALU;
         end
         default: mem_req = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised bench for multicycle_control against a table-driven instruction model.
// Latency: checks every cycle of every instruction.
// Backpressure: randomised mem_ready wait cycles in FETCH and MEM.
module tb_multicycle_control;

   localparam logic [2:0] K_ALU = 3'd0, K_LD = 3'd1, K_ST = 3'd2, K_BR = 3'd3, K_JAL = 3'd4;

   typedef struct packed {
      logic [6:0] op;
      logic [2:0] f3;
      logic       f3c;
      logic [6:0] f7;
      logic       f7c;
      logic [3:0] alu;
      logic [2:0] br;
      logic       src;
      logic [2:0] cls;
   } row_t;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       ir_we;
      logic       reg_we;
      logic       pc_we;
      logic       pc_sel;
      logic [1:0] wb_sel;
      logic [3:0] alu_op;
      logic [2:0] branch;
      logic       alu_src_b;
      logic       illegal;
   } out_t;

   typedef struct packed {
      logic        rdy;
      logic        zero;
      logic [31:0] ins;
      out_t        out;
   } entry_t;

   logic        clk = 1'b0;
   logic        reset, mem_ready, zero;
   logic [31:0] instr_rdata;
   logic [3:0]  alu_op;
   logic [2:0]  branch;
   logic [1:0]  wb_sel;
   logic        alu_src_b, mem_req, mem_we, ir_we, reg_we, pc_we, pc_sel, illegal;
   out_t        obs;

   int tests_run = 0;
   int tests_failed = 0;

   row_t   tbl[$];
   entry_t exp_q[$];
   row_t   m_ir;

   always #5 clk = ~clk;

   multicycle_control #(.alu_op_size(4), .instr_size(32)) dut (
      .clk(clk), .reset(reset), .instr_rdata(instr_rdata), .mem_ready(mem_ready), .zero(zero),
      .alu_op(alu_op), .branch(branch), .alu_src_b(alu_src_b), .mem_req(mem_req), .mem_we(mem_we),
      .ir_we(ir_we), .reg_we(reg_we), .pc_we(pc_we), .pc_sel(pc_sel), .wb_sel(wb_sel), .illegal(illegal)
   );

   assign obs = {mem_req, mem_we, ir_we, reg_we, pc_we, pc_sel, wb_sel, alu_op, branch, alu_src_b, illegal};

   // ---------------- reference model ----------------
   task automatic add_row(input logic [6:0] op, input logic [2:0] f3, input logic f3c, input logic [6:0] f7,
                          input logic f7c, input logic [3:0] alu, input logic [2:0] br, input logic src,
                          input logic [2:0] cls);
      row_t r;
      r = '{op, f3, f3c, f7, f7c, alu, br, src, cls};
      tbl.push_back(r);
   endtask

   task automatic build_table();
      add_row(7'h33, 3'd0, 1, 7'h00, 1, 4'b0010, 3'd0, 0, K_ALU); // add
      add_row(7'h33, 3'd0, 1, 7'h20, 1, 4'b0110, 3'd0, 0, K_ALU); // sub
      add_row(7'h33, 3'd7, 1, 7'h00, 1, 4'b0000, 3'd0, 0, K_ALU); // and
      add_row(7'h33, 3'd6, 1, 7'h00, 1, 4'b0001, 3'd0, 0, K_ALU); // or
      add_row(7'h33, 3'd4, 1, 7'h00, 1, 4'b0011, 3'd0, 0, K_ALU); // xor
      add_row(7'h33, 3'd1, 1, 7'h00, 1, 4'b0100, 3'd0, 0, K_ALU); // sll
      add_row(7'h33, 3'd5, 1, 7'h00, 1, 4'b0101, 3'd0, 0, K_ALU); // srl
      add_row(7'h13, 3'd0, 1, 7'h00, 0, 4'b0010, 3'd0, 1, K_ALU); // addi
      add_row(7'h13, 3'd7, 1, 7'h00, 0, 4'b0000, 3'd0, 1, K_ALU); // andi
      add_row(7'h13, 3'd6, 1, 7'h00, 0, 4'b0001, 3'd0, 1, K_ALU); // ori
      add_row(7'h13, 3'd4, 1, 7'h00, 0, 4'b0011, 3'd0, 1, K_ALU); // xori
      add_row(7'h13, 3'd1, 1, 7'h00, 1, 4'b1100, 3'd0, 1, K_ALU); // slli
      add_row(7'h13, 3'd5, 1, 7'h00, 1, 4'b1101, 3'd0, 1, K_ALU); // srli
      add_row(7'h03, 3'd2, 1, 7'h00, 0, 4'b0010, 3'd0, 1, K_LD);  // lw
      add_row(7'h23, 3'd2, 1, 7'h00, 0, 4'b0010, 3'd0, 1, K_ST);  // sw
      add_row(7'h63, 3'd0, 1, 7'h00, 0, 4'b0110, 3'd0, 0, K_BR);  // beq
      add_row(7'h63, 3'd1, 1, 7'h00, 0, 4'b0110, 3'd1, 0, K_BR);  // bne
      add_row(7'h63, 3'd4, 1, 7'h00, 0, 4'b0110, 3'd4, 0, K_BR);  // blt
      add_row(7'h63, 3'd5, 1, 7'h00, 0, 4'b0110, 3'd5, 0, K_BR);  // bge
      add_row(7'h63, 3'd6, 1, 7'h00, 0, 4'b0110, 3'd6, 0, K_BR);  // bltu
      add_row(7'h63, 3'd7, 1, 7'h00, 0, 4'b0110, 3'd7, 0, K_BR);  // bgeu
      add_row(7'h6F, 3'd0, 0, 7'h00, 0, 4'b0010, 3'd2, 0, K_JAL); // jal
   endtask

   // Unsupported words behave as ADD, no branch, rs2 operand
   task automatic ref_decode(input logic [31:0] w, output row_t d, output logic legal);
      d = '{7'h00, 3'd0, 1'b0, 7'h00, 1'b0, 4'b0010, 3'd0, 1'b0, K_ALU};
      legal = 1'b0;
      foreach (tbl[i]) begin
         if (tbl[i].op == w[6:0] && (!tbl[i].f3c || tbl[i].f3 == w[14:12]) &&
             (!tbl[i].f7c || tbl[i].f7 == w[31:25])) begin
            d = tbl[i];
            legal = 1'b1;
         end
      end
   endtask

   function automatic out_t base_out();
      out_t o;
      o = '0;
      o.alu_op = m_ir.alu;
      o.branch = m_ir.br;
      o.alu_src_b = m_ir.src;
      return o;
   endfunction

   task automatic push(input logic rdy, input logic zv, input logic [31:0] ins, input out_t o);
      entry_t e;
      e = '{rdy, zv, ins, o};
      exp_q.push_back(e);
   endtask

   // One cycle right after reset: nothing issued yet, instruction register cleared
   task automatic model_reset();
      logic lg;
      ref_decode(32'h0, m_ir, lg);
      push(1'($urandom), 1'($urandom), $urandom, base_out());
   endtask

   task automatic model_instr(input logic [31:0] w, input logic zv, input int fw, input int mw);
      row_t d;
      logic lg;
      out_t o;
      ref_decode(w, d, lg);
      for (int i = 0; i <= fw; i++) begin
         o = base_out();
         o.mem_req = 1'b1;
         o.ir_we = (i == fw);
         push(i == fw, 1'($urandom), w, o);
      end
      m_ir = d;
      push(1'($urandom), 1'($urandom), $urandom, base_out());
      if (!lg) begin
         repeat (4) begin
            o = base_out();
            o.illegal = 1'b1;
            push(1'($urandom), 1'($urandom), $urandom, o);
         end
         return;
      end
      o = base_out();
      if (d.cls == K_BR) begin
         o.pc_we = 1'b1;
         o.pc_sel = zv;
      end else if (d.cls == K_JAL) begin
         o.pc_we = 1'b1;
         o.pc_sel = 1'b1;
      end
      push(1'($urandom), (d.cls == K_BR) ? zv : 1'($urandom), $urandom, o);
      if (d.cls == K_LD || d.cls == K_ST) begin
         for (int i = 0; i <= mw; i++) begin
            o = base_out();
            o.mem_req = 1'b1;
            o.mem_we = (d.cls == K_ST);
            o.pc_we = (d.cls == K_ST) && (i == mw);
            push(i == mw, 1'($urandom), $urandom, o);
         end
      end
      if (d.cls == K_ALU || d.cls == K_LD || d.cls == K_JAL) begin
         o = base_out();
         o.reg_we = 1'b1;
         o.pc_we = (d.cls != K_JAL);
         o.wb_sel = (d.cls == K_LD) ? 2'b01 : (d.cls == K_JAL) ? 2'b10 : 2'b00;
         push(1'($urandom), 1'($urandom), $urandom, o);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      entry_t e;
      do_reset();
      model_reset();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         mem_ready = e.rdy; zero = e.zero; instr_rdata = e.ins;
         @(negedge clk);
         tests_run++;
         if (obs !== e.out) begin
            tests_failed++;
            $display("FAIL reset_state: got %h expected %h", obs, e.out);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_alu();
      entry_t e;
      int step = 0;
      model_instr(32'h002081B3, 1'b0, 0, 0); // add: exactly 4 cycles
      model_instr(32'h402081B3, 1'b0, 1, 0); // sub
      model_instr(32'h00209093, 1'b0, 0, 0); // slli
      model_instr(32'h0020D093, 1'b0, 2, 0); // srli
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         mem_ready = e.rdy; zero = e.zero; instr_rdata = e.ins;
         @(negedge clk);
         tests_run++;
         if (obs !== e.out) begin
            tests_failed++;
            $display("FAIL alu step %0d: got %h expected %h", step, obs, e.out);
         end
         step++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch();
      entry_t e;
      int step = 0;
      model_instr(32'h00208463, 1'b1, 0, 0); // beq taken
      model_instr(32'h00208463, 1'b0, 0, 0); // beq not taken
      model_instr(32'h0080006F, 1'b0, 0, 0); // jal
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         mem_ready = e.rdy; zero = e.zero; instr_rdata = e.ins;
         @(negedge clk);
         tests_run++;
         if (obs !== e.out) begin
            tests_failed++;
            $display("FAIL branch step %0d: got %h expected %h", step, obs, e.out);
         end
         step++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load_store();
      entry_t e;
      int step = 0;
      model_instr(32'h0000A283, 1'b0, 0, 3); // lw with 3 wait cycles in MEM
      model_instr(32'h0050A223, 1'b0, 1, 2); // sw
      model_instr(32'h0050A223, 1'b0, 0, 0); // sw back to back
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         mem_ready = e.rdy; zero = e.zero; instr_rdata = e.ins;
         @(negedge clk);
         tests_run++;
         if (obs !== e.out) begin
            tests_failed++;
            $display("FAIL load_store step %0d: got %h expected %h", step, obs, e.out);
         end
         step++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_random_legal();
      entry_t e;
      row_t r;
      logic [31:0] w;
      int step = 0;
      for (int n = 0; n < 80; n++) begin
         r = tbl[$urandom_range(0, tbl.size() - 1)];
         w = $urandom;
         w[6:0] = r.op;
         if (r.f3c) w[14:12] = r.f3;
         if (r.f7c) w[31:25] = r.f7;
         model_instr(w, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         mem_ready = e.rdy; zero = e.zero; instr_rdata = e.ins;
         @(negedge clk);
         tests_run++;
         if (obs !== e.out) begin
            tests_failed++;
            $display("FAIL random step %0d: got %h expected %h", step, obs, e.out);
         end
         step++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_illegal();
      entry_t e;
      logic [31:0] w;
      int step = 0;
      for (int n = 0; n < 25; n++) begin
         w = $urandom;
         if (n == 0) w = 32'h0;
         else if (n % 2 == 0) w[6:0] = tbl[$urandom_range(0, tbl.size() - 1)].op;
         do_reset();
         model_reset();
         model_instr(w, 1'($urandom), $urandom_range(0, 1), $urandom_range(0, 1));
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            mem_ready = e.rdy; zero = e.zero; instr_rdata = e.ins;
            @(negedge clk);
            tests_run++;
            if (obs !== e.out) begin
               tests_failed++;
               $display("FAIL illegal word %h step %0d: got %h expected %h", w, step, obs, e.out);
            end
            step++;
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_reset_mid_mem();
      entry_t e;
      out_t rst_exp;
      do_reset();
      model_reset();
      model_instr(32'h0000A283, 1'b0, 0, 10);
      // reset-recovery, fetch, decode, execute, then three stalled MEM cycles
      for (int k = 0; k < 7; k++) begin
         e = exp_q.pop_front();
         mem_ready = e.rdy; zero = e.zero; instr_rdata = e.ins;
         @(negedge clk);
         tests_run++;
         if (obs !== e.out) begin
            tests_failed++;
            $display("FAIL mid_mem step %0d: got %h expected %h", k, obs, e.out);
         end
         @(posedge clk); #1;
      end
      exp_q.delete();
      mem_ready = 1'b0;
      do_reset();
      rst_exp = '0;
      rst_exp.alu_op = 4'b0010;
      @(negedge clk);
      tests_run++;
      if (obs !== rst_exp) begin
         tests_failed++;
         $display("FAIL mid_mem_reset: got %h expected %h", obs, rst_exp);
      end
      @(posedge clk); #1;
      @(negedge clk);
      tests_run++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_mem_refetch: mem_req %b mem_we %b expected 1 0", mem_req, mem_we);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1;
      mem_ready = 1'b0;
      zero = 1'b0;
      instr_rdata = '0;
      build_table();
      @(posedge clk); #1;
      test_reset();
      test_alu();
      test_branch();
      test_load_store();
      test_random_legal();
      test_illegal();
      test_reset_mid_mem();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
